multicycle_ctl: RTL and testbench
=================================

# multicycle_ctl

Main control FSM for the multicycle MIPS datapath; produces the 2-bit ALUOp and the 6-bit function field consumed by the ALU control decoder, plus every datapath enable and mux select. It sequences fetch, decode, execute, memory and write-back per instruction and stalls on a memory ready handshake. It sits between the instruction register (opcode/funct) and the datapath muxes and register enables.

## Interface
- No parameters; all widths fixed by the ISA.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite, PCWriteCond, PCWriteCondNe  out  1 each  unconditional / beq / bne PC enables.
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  standard multicycle controls.
- ALUSrcB, PCSource, ALUOp  out  2 each  mux selects and ALU operation class.
- alu_funct  out  6  function field to ALU control.
- illegal  out  1  sticky illegal-opcode flag (macro-dependent).

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100.
- ALUOp codes: 11 add (fetch, decode, address), 01 subtract (branch), 10 R-type by funct, 00 I-type by alu_funct.
- alu_funct = opcode in IEXE, else funct.
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, BRANCH 8, JUMP 9, IEXE 10, IWB 11, TRAP 12.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=11, PCSource=00; IRWrite and PCWrite only when mem_ready=1; advance to DECODE on mem_ready, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=11; next by opcode: lw/sw→MEMADR, R→RTEXE, beq/bne→BRANCH, j→JUMP, addi/andi→IEXE, other→see Configuration.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=11; lw→MEMRD, sw→MEMWR.
- MEMRD: MemRead, IorD=1; hold until mem_ready, then MEMWB. MEMWB: RegWrite, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWrite, IorD=1; hold until mem_ready → FETCH. MemWrite stays high while holding.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RTWB: RegWrite, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; PCWriteCond if opcode[0]=0, PCWriteCondNe if opcode[0]=1 → FETCH.
- JUMP: PCWrite, PCSource=10 → FETCH.
- IEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → IWB: RegWrite, RegDst=0, MemtoReg=0 → FETCH.
- Unlisted outputs are 0 in each state.

## Timing
- Moore outputs from state register; only FETCH IRWrite/PCWrite gated by mem_ready (combinational).
- While reset high: all enables (PCWrite*, MemRead, MemWrite, IRWrite, RegWrite) forced 0, selects 0, ALUOp 00, illegal 0.
- Reset mid-instruction aborts immediately; first post-reset cycle is FETCH.
- Zero-wait cycles per instruction: lw 5, sw 4, R 4, addi/andi 4, beq/bne 3, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- opcode/funct sampled combinationally; must be stable from DECODE to instruction end (IR written only in FETCH).

## Configuration
- MCTL_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE → TRAP; TRAP asserts illegal=1, all enables 0, holds until reset.
- Undefined: unknown opcode treated as nop, DECODE → FETCH; illegal tied 0; TRAP unreachable/absent.

## Structure
- Shared package mips_pkg: opcode constants, ALUOp codes, state encodings, PCSource/ALUSrcB codes (shared with ALU control and datapath).
- One sub-module mctl_outdec: combinational state+opcode → control word decoder; FSM top holds state register and next-state logic.

## Test plan
- Reset pulse mid-MEMRD → all enables 0 during reset; FETCH with MemRead=1 next cycle.
- lw, mem_ready=1 always → states 0,1,2,3,4 over 5 cycles; RegWrite=1 and MemtoReg=1 only in cycle 5.
- R-type funct 100010 → ALUOp=10, alu_funct=100010 in RTEXE; addi → ALUOp=00, alu_funct=001000 in IEXE.
- sw with mem_ready low 3 cycles in MEMWR → MemWrite held 4 cycles, 7 total cycles, then FETCH.
- beq then bne → PCWriteCond=1 only for beq, PCWriteCondNe=1 only for bne, ALUOp=01, PCSource=01.
- opcode 111111 → with MCTL_ILLEGAL_TRAP_EN illegal=1 and stuck in TRAP; without, FETCH after DECODE, no write enables.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ISA constants, control selects and FSM state encodings for the multicycle MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALUOP_ITYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [5:0] alu_funct;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/multicycle_ctl_if.sv
// rtl/multicycle_ctl_if.sv - instruction fields, memory handshake and control word between controller and datapath
interface multicycle_ctl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [5:0] alu_funct;
    logic       illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, alu_funct, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, alu_funct, illegal
    );
endinterface

// File: rtl/mctl_outdec.sv
// rtl/mctl_outdec.sv - combinational state/opcode to control word decoder (Moore, except FETCH IR/PC writes)
module mctl_outdec
    import mips_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output ctl_t       ctl_o
);

    always_comb begin
        ctl_o           = '0;
        ctl_o.alu_funct = funct_i;
        case (state_i)
            S_FETCH: begin
                ctl_o.mem_read  = 1'b1;
                ctl_o.alu_src_b = SRCB_FOUR;
                ctl_o.alu_op    = ALUOP_ADD;
                ctl_o.pc_source = PCSRC_ALU;
                // IR and PC only capture once the fetch has actually returned
                ctl_o.ir_write  = mem_ready_i;
                ctl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctl_o.alu_src_b = SRCB_BRANCH;
                ctl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_IMM;
                ctl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctl_o.mem_read = 1'b1;
                ctl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl_o.reg_write  = 1'b1;
                ctl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctl_o.mem_write = 1'b1;
                ctl_o.iord      = 1'b1;
            end
            S_RTEXE: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_REG;
                ctl_o.alu_op    = ALUOP_RTYPE;
            end
            S_RTWB: begin
                ctl_o.reg_write = 1'b1;
                ctl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl_o.alu_src_a        = 1'b1;
                ctl_o.alu_src_b        = SRCB_REG;
                ctl_o.alu_op           = ALUOP_SUB;
                ctl_o.pc_source        = PCSRC_ALUOUT;
                ctl_o.pc_write_cond    = ~opcode_i[0];
                ctl_o.pc_write_cond_ne = opcode_i[0];
            end
            S_JUMP: begin
                ctl_o.pc_write  = 1'b1;
                ctl_o.pc_source = PCSRC_JUMP;
            end
            S_IEXE: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_IMM;
                ctl_o.alu_op    = ALUOP_ITYPE;
                ctl_o.alu_funct = opcode_i;
            end
            S_IWB: begin
                ctl_o.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctl_o.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctl.sv
// rtl/multicycle_ctl.sv - multicycle MIPS control FSM; MCTL_ILLEGAL_TRAP_EN enables the sticky illegal-opcode trap
module multicycle_ctl
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    multicycle_ctl_if.master bus
);

    state_t state_q, state_d;
    ctl_t   ctl, ctl_g;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:      state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_RTEXE;
                    OP_BEQ, OP_BNE:    state_d = S_BRANCH;
                    OP_J:              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI:  state_d = S_IEXE;
`ifdef MCTL_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXE:   state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
`ifdef MCTL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mctl_outdec u_outdec (
        .state_i     (state_q),
        .opcode_i    (bus.opcode),
        .funct_i     (bus.funct),
        .mem_ready_i (bus.mem_ready),
        .ctl_o       (ctl)
    );

    // The state register already reads FETCH during reset; mask so nothing fires until release
    always_comb begin
        ctl_g = ctl;
        if (reset) ctl_g = '0;
    end

    assign bus.PCWrite       = ctl_g.pc_write;
    assign bus.PCWriteCond   = ctl_g.pc_write_cond;
    assign bus.PCWriteCondNe = ctl_g.pc_write_cond_ne;
    assign bus.IorD          = ctl_g.iord;
    assign bus.MemRead       = ctl_g.mem_read;
    assign bus.MemWrite      = ctl_g.mem_write;
    assign bus.IRWrite       = ctl_g.ir_write;
    assign bus.MemtoReg      = ctl_g.mem_to_reg;
    assign bus.RegWrite      = ctl_g.reg_write;
    assign bus.RegDst        = ctl_g.reg_dst;
    assign bus.ALUSrcA       = ctl_g.alu_src_a;
    assign bus.ALUSrcB       = ctl_g.alu_src_b;
    assign bus.PCSource      = ctl_g.pc_source;
    assign bus.ALUOp         = ctl_g.alu_op;
    assign bus.alu_funct     = ctl_g.alu_funct;
    assign bus.illegal       = ctl_g.illegal;

endmodule

// File: tb/tb_multicycle_ctl.sv
// tb/tb_multicycle_ctl.sv - self-checking bench for multicycle_ctl; follows MCTL_ILLEGAL_TRAP_EN when defined
module tb_multicycle_ctl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_ctl_if bus ();

    multicycle_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [5:0] cur_op, cur_fn;

    localparam logic [23:0] RESET_MASK = 24'hFFFF81;

    function automatic logic [23:0] observed();
        return {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.alu_funct, bus.illegal};
    endfunction

    // Reference control word for one named instruction step, straight from the control table
    function automatic logic [23:0] expect_word(string st, logic [5:0] op, logic [5:0] fn, logic mr);
        logic pcw, pcc, pcn, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill;
        logic [1:0] sb, ps, ao;
        logic [5:0] af;
        {pcw, pcc, pcn, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00; af = fn;
        case (st)
            "F":  begin mrd = 1; sb = 2'b01; ao = 2'b11; irw = mr; pcw = mr; end
            "D":  begin sb = 2'b11; ao = 2'b11; end
            "A":  begin sa = 1; sb = 2'b10; ao = 2'b11; end
            "RD": begin mrd = 1; iord = 1; end
            "WB": begin rw = 1; m2r = 1; end
            "WR": begin mwr = 1; iord = 1; end
            "RX": begin sa = 1; ao = 2'b10; end
            "RW": begin rw = 1; rd = 1; end
            "B":  begin sa = 1; ao = 2'b01; ps = 2'b01; pcc = (op == 6'b000100); pcn = (op == 6'b000101); end
            "J":  begin pcw = 1; ps = 2'b10; end
            "IX": begin sa = 1; sb = 2'b10; af = op; end
            "IW": begin rw = 1; end
            "T":  begin ill = 1; end
            default: ;
        endcase
        return {pcw, pcc, pcn, iord, mrd, mwr, irw, m2r, rw, rd, sa, sb, ps, ao, af, ill};
    endfunction

    function automatic bit is_mem(string st);
        return (st == "F") || (st == "RD") || (st == "WR");
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b000010, 6'b001000, 6'b001100};
    endfunction

    task automatic check(string tag, logic [23:0] got, logic [23:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(string st, logic mr);
        bus.mem_ready = mr;
        @(negedge clk);
        check($sformatf("step %s op=%b", st, cur_op), observed(), expect_word(st, cur_op, cur_fn, mr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset", observed() & RESET_MASK, 24'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // mode: 0 always ready, 1 random ready, 2 three stalls in WR, 3 RD never ready
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int mode, int limit);
        string steps[$];
        int used;
        int stalls;
        int guard;
        logic mr;
        used = 0; stalls = 0;
        cur_op = op; cur_fn = fn;
        bus.opcode = op; bus.funct = fn;
        case (op)
            6'b100011: steps = {"F", "D", "A", "RD", "WB"};
            6'b101011: steps = {"F", "D", "A", "WR"};
            6'b000000: steps = {"F", "D", "RX", "RW"};
            6'b001000, 6'b001100: steps = {"F", "D", "IX", "IW"};
            6'b000100, 6'b000101: steps = {"F", "D", "B"};
            6'b000010: steps = {"F", "D", "J"};
`ifdef MCTL_ILLEGAL_TRAP_EN
            default: steps = {"F", "D", "T", "T", "T", "T", "T"};
`else
            default: steps = {"F", "D"};
`endif
        endcase
        foreach (steps[i]) begin
            guard = 0;
            forever begin
                mr = 1'($urandom_range(0, 1));
                if (is_mem(steps[i])) begin
                    mr = 1'b1;
                    case (mode)
                        1: mr = ($urandom_range(0, 2) != 0);
                        2: if (steps[i] == "WR" && stalls < 3) begin mr = 1'b0; stalls++; end
                        3: if (steps[i] == "RD") mr = 1'b0;
                        default: ;
                    endcase
                end
                cycle(steps[i], mr);
                used++;
                if (limit != 0 && used >= limit) return;
                if (mr || !is_mem(steps[i])) break;
                guard++;
                if (guard > 100) begin
                    n_checks++;
                    n_fails++;
                    $error("FAIL timeout in step %s: observed no completion, expected within 100 cycles", steps[i]);
                    return;
                end
            end
        end
    endtask

    logic [5:0] op_tab [9];
    logic [5:0] rop;

    initial begin
        op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                   6'b000010, 6'b001000, 6'b001100, 6'b111110};
        bus.opcode = 6'b0; bus.funct = 6'b0; bus.mem_ready = 1'b0;
        cur_op = 6'b0; cur_fn = 6'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(6'b100011, 6'($urandom), 0, 0);
        run_instr(6'b000000, 6'b100010, 0, 0);
        run_instr(6'b001000, 6'($urandom), 0, 0);
        run_instr(6'b001100, 6'($urandom), 0, 0);
        run_instr(6'b101011, 6'($urandom), 2, 0);
        run_instr(6'b000100, 6'($urandom), 0, 0);
        run_instr(6'b000101, 6'($urandom), 0, 0);

        run_instr(6'b100011, 6'($urandom), 3, 5);
        do_reset();
        run_instr(6'b000010, 6'($urandom), 0, 0);

        for (int k = 0; k < 60; k++) begin
            rop = op_tab[$urandom_range(0, 8)];
            run_instr(rop, 6'($urandom), 1, 0);
`ifdef MCTL_ILLEGAL_TRAP_EN
            if (!is_legal(rop)) do_reset();
`endif
        end

        run_instr(6'b111111, 6'($urandom), 0, 0);
`ifdef MCTL_ILLEGAL_TRAP_EN
        do_reset();
`endif
        run_instr(6'b100011, 6'($urandom), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
